// File: rtl/intt_output_serializer.sv
// intt_output_serializer
//
// Captures one full transformed polynomial from the intt_processor result
// burst (one wide beat per cycle, no backpressure upstream) and replays it
// as a stream of 30-bit coefficients in natural order over valid/ready.
//
// Ports:
//   clk            system clock, everything on posedge
//   rst            synchronous active-high reset
//   in_data        upstream result words [core][word]; each 60-bit word
//                  packs two coefficients, low field [29:0], high [59:30]
//   in_address     upstream beat index; only the low row bits are used
//   in_active      upstream beat valid
//   m_data         output coefficient
//   m_index        coefficient index of m_data
//   m_valid        output valid
//   m_ready        output ready
//   m_last         marks coefficient N-1
//   busy           high while draining; upstream must not start a transform
//   overrun        sticky flag: a beat arrived while draining and was dropped
//   overrun_count  dropped-beat counter, saturating at 16'hFFFF
//
// Build option: define INTT_SER_OVERRUN_CNT_EN to enable overrun_count;
// without it overrun_count is tied to zero.

module intt_output_serializer #(
  parameter int LOG_CORE_COUNT = 4,
  parameter int LOG_N          = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [59:0]       in_data [(1<<LOG_CORE_COUNT)-1:0][1:0],
  input  logic [8:0]        in_address,
  input  logic              in_active,
  output logic [29:0]       m_data,
  output logic [LOG_N-1:0]  m_index,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       overrun_count
);

  localparam int ROW_BITS        = LOG_N - 2 - LOG_CORE_COUNT;
  localparam int COL_BITS        = LOG_CORE_COUNT + 2;
  localparam int BEATS           = 1 << ROW_BITS;
  localparam int COEFFS_PER_BEAT = 4 << LOG_CORE_COUNT;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t               state;
  logic [ROW_BITS-1:0]  beat_cnt;
  logic [LOG_N-1:0]     rd_idx;
  logic [ROW_BITS-1:0]  wr_row;
  logic [ROW_BITS-1:0]  rd_row;
  logic                 wr_en;
  logic [29:0]          col_rd [COEFFS_PER_BEAT];
  logic [29:0]          rd_coeff;
  logic                 unused_addr_hi;

  // Address bits above the row range carry no meaning for this buffer.
  assign unused_addr_hi = ^in_address[8:ROW_BITS];

  assign wr_row   = in_address[ROW_BITS-1:0];
  assign wr_en    = (state == FILL) && in_active && !rst;
  assign rd_row   = rd_idx[LOG_N-1:COL_BITS];
  assign rd_coeff = col_rd[rd_idx[COL_BITS-1:0]];

  // The buffer is split into one column memory per coefficient slot of a
  // beat, so a whole beat lands in a single write while the drain side
  // reads one coefficient at a time. Column k holds coefficient 4*i+j of
  // each row: core i = k/4, word j/2, field j%2.
  generate
    for (genvar k = 0; k < COEFFS_PER_BEAT; k++) begin : g_col
      logic [29:0] col_mem [BEATS];

      always_ff @(posedge clk) begin
        if (wr_en)
          col_mem[wr_row] <= in_data[k/4][(k/2)%2][(k%2)*30 +: 30];
      end

      assign col_rd[k] = col_mem[rd_row];
    end
  endgenerate

  // Control FSM. The output register is loaded straight from the buffer
  // whenever it is empty or being consumed, which gives one coefficient per
  // cycle under continuous ready and holds everything stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      beat_cnt <= '0;
      rd_idx   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      m_index  <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_active) begin
            if (beat_cnt == ROW_BITS'(BEATS - 1)) begin
              state    <= DRAIN;
              busy     <= 1'b1;
              beat_cnt <= '0;
              rd_idx   <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (in_active)
            overrun <= 1'b1;
          if (m_valid && m_ready && m_last) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            state   <= FILL;
          end else if (!m_valid || m_ready) begin
            m_data  <= rd_coeff;
            m_index <= rd_idx;
            m_last  <= (rd_idx == '1);
            m_valid <= 1'b1;
            rd_idx  <= rd_idx + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef INTT_SER_OVERRUN_CNT_EN
  // Counts every beat dropped while draining, including one arriving on
  // the same edge as the final transfer.
  always_ff @(posedge clk) begin
    if (rst)
      overrun_count <= '0;
    else if ((state == DRAIN) && in_active && (overrun_count != 16'hFFFF))
      overrun_count <= overrun_count + 1'b1;
  end
`else
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_intt_output_serializer.sv
// tb_intt_output_serializer
//
// Self-checking bench for intt_output_serializer at default parameters.
// A reference buffer of N coefficients is filled from each accepted beat
// using the coefficient ordering rule; the drained stream must replay it in
// index order. A small table of packing vectors checks the field layout
// against hand-computed constants.

module tb_intt_output_serializer;

  localparam int N     = 4096;
  localparam int BEATS = 64;
  localparam int CPB   = 64;
  localparam int CORES = 16;

`ifdef INTT_SER_OVERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [59:0] in_data [CORES-1:0][1:0];
  logic [8:0]  in_address;
  logic        in_active;
  logic [29:0] m_data;
  logic [11:0] m_index;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        overrun;
  logic [15:0] overrun_count;

  logic [59:0] beat_data [CORES-1:0][1:0];
  logic [29:0] ref_mem [N];
  logic [29:0] cap [N];
  int          checks;
  int          errors;
  int          ovr_cnt;
  int          cyc;

  typedef struct {
    int          core;
    logic [59:0] w0;
    logic [59:0] w1;
    logic [29:0] e0;
    logic [29:0] e1;
    logic [29:0] e2;
    logic [29:0] e3;
  } vec_t;

  vec_t vecs [4];

  intt_output_serializer #(.LOG_CORE_COUNT(4), .LOG_N(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_address    (in_address),
    .in_active     (in_active),
    .m_data        (m_data),
    .m_index       (m_index),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [59:0] rand60();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[59:0];
  endfunction

  function automatic int bitrev6(input int b);
    int r;
    r = 0;
    for (int k = 0; k < 6; k++)
      r |= ((b >> k) & 1) << (5 - k);
    return r;
  endfunction

  // Reference model: coefficient row*64 + 4*i + j comes from core i,
  // word j/2, low field for even j and high field for odd j.
  task automatic model_capture(input int row);
    logic [59:0] w;
    for (int i = 0; i < CORES; i++)
      for (int j = 0; j < 4; j++) begin
        w = beat_data[i][j/2];
        ref_mem[row*CPB + 4*i + j] = (j % 2 == 1) ? w[59:30] : w[29:0];
      end
  endtask

  // Fills one polynomial. mode 0: ordered rows, payload = index;
  // 1: bit-reversed rows, payload = index; 2: random rows/data with idle
  // gaps and junk upper address bits; 3: ordered rows, random data, with
  // the packing table placed into beat 0.
  task automatic apply_stimulus(input int mode);
    int         row;
    logic [2:0] hi;
    for (int b = 0; b < BEATS; b++) begin
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        in_active = 1'b0;
        @(posedge clk); #1;
        check_output("idle_busy", busy, 0);
      end
      case (mode)
        0, 3:    row = b;
        1:       row = bitrev6(b);
        default: row = $urandom_range(0, 63);
      endcase
      hi = (mode >= 2) ? 3'($urandom_range(0, 7)) : 3'd0;
      for (int i = 0; i < CORES; i++)
        for (int w = 0; w < 2; w++) begin
          if (mode <= 1)
            beat_data[i][w] = {30'(row*CPB + 4*i + 2*w + 1), 30'(row*CPB + 4*i + 2*w)};
          else
            beat_data[i][w] = rand60();
        end
      if (mode == 3 && b == 0)
        for (int v = 0; v < 4; v++) begin
          beat_data[vecs[v].core][0] = vecs[v].w0;
          beat_data[vecs[v].core][1] = vecs[v].w1;
        end
      check_output("fill_busy", busy, 0);
      check_output("fill_valid", m_valid, 0);
      in_data    = beat_data;
      in_address = {hi, 6'(row)};
      in_active  = 1'b1;
      model_capture(row);
      @(posedge clk); #1;
    end
    in_active = 1'b0;
    check_output("drain_start_busy", busy, 1);
    check_output("drain_start_valid", m_valid, 0);
  endtask

  // Drains up to max_xfer coefficients. ready mode 0: always high;
  // 1: pattern 1,0,0,1; 2: random. Injects ovr_beats dropped beats (aimed
  // at row 63) starting once ovr_at coefficients have transferred.
  task automatic drain_check(input int mode, input int max_xfer, input int ovr_at,
                             input int ovr_beats, input bit ident, output int cycles);
    int          idx;
    int          inj;
    bit          prev_stall;
    bit          xfer;
    logic [29:0] held_data;
    logic [11:0] held_idx;
    idx = 0; cycles = 0; inj = ovr_beats; prev_stall = 0;
    held_data = '0; held_idx = '0;
    while (idx < max_xfer && cycles < 20000) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cycles % 4 == 0) || (cycles % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (inj > 0 && idx >= ovr_at && m_valid) begin
        for (int i = 0; i < CORES; i++)
          for (int w = 0; w < 2; w++)
            beat_data[i][w] = rand60();
        in_data    = beat_data;
        in_address = {3'b101, 6'd63};
        in_active  = 1'b1;
        inj--;
        ovr_cnt++;
      end else begin
        in_active = 1'b0;
      end
      check_output("drain_busy", busy, 1);
      if (prev_stall) begin
        check_output("hold_valid", m_valid, 1);
        check_output("hold_data", m_data, held_data);
        check_output("hold_index", m_index, held_idx);
      end
      if (m_valid) begin
        check_output("index", m_index, idx);
        check_output("data", m_data, ref_mem[idx]);
        check_output("last", m_last, (idx == N - 1));
        if (ident)
          check_output("data_eq_index", m_data, idx);
        cap[idx] = m_data;
      end
      prev_stall = m_valid && !m_ready;
      held_data  = m_data;
      held_idx   = m_index;
      xfer       = m_valid && m_ready;
      @(posedge clk); #1;
      if (xfer)
        idx++;
      cycles++;
    end
    in_active = 1'b0;
    check_output("drain_transfers", idx, max_xfer);
    if (max_xfer == N) begin
      check_output("end_valid", m_valid, 0);
      check_output("end_busy", busy, 0);
    end
  endtask

  initial begin
    vecs[0] = '{core: 0,  w0: {30'd2, 30'd1}, w1: {30'd4, 30'd3},
                e0: 30'd1, e1: 30'd2, e2: 30'd3, e3: 30'd4};
    vecs[1] = '{core: 7,  w0: {30'h3FFFFFFF, 30'h0}, w1: {30'h0, 30'h2AAAAAAA},
                e0: 30'h0, e1: 30'h3FFFFFFF, e2: 30'h2AAAAAAA, e3: 30'h0};
    vecs[2] = '{core: 9,  w0: {30'h15555555, 30'h2AAAAAAA}, w1: {30'h3C3C3C3C, 30'h03C3C3C3},
                e0: 30'h2AAAAAAA, e1: 30'h15555555, e2: 30'h03C3C3C3, e3: 30'h3C3C3C3C};
    vecs[3] = '{core: 15, w0: {30'h12345678, 30'h0ABCDEF0}, w1: {30'h1, 30'h3FFFFFFE},
                e0: 30'h0ABCDEF0, e1: 30'h12345678, e2: 30'h3FFFFFFE, e3: 30'h1};

    checks = 0; errors = 0; ovr_cnt = 0;
    rst = 1'b1; in_active = 1'b0; m_ready = 1'b0; in_address = '0;
    for (int i = 0; i < CORES; i++)
      for (int w = 0; w < 2; w++)
        beat_data[i][w] = '0;
    in_data = beat_data;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid", m_valid, 0);
    check_output("rst_last", m_last, 0);
    check_output("rst_data", m_data, 0);
    check_output("rst_index", m_index, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_overrun_count", overrun_count, 0);
    rst = 1'b0;

    $display("[TB] packing table");
    apply_stimulus(3);
    drain_check(2, N, N, 0, 1'b0, cyc);
    for (int v = 0; v < 4; v++) begin
      check_output("pack_j0", cap[4*vecs[v].core + 0], vecs[v].e0);
      check_output("pack_j1", cap[4*vecs[v].core + 1], vecs[v].e1);
      check_output("pack_j2", cap[4*vecs[v].core + 2], vecs[v].e2);
      check_output("pack_j3", cap[4*vecs[v].core + 3], vecs[v].e3);
    end

    $display("[TB] ordered fill, full-rate drain");
    apply_stimulus(0);
    drain_check(0, N, N, 0, 1'b1, cyc);
    check_output("full_rate_cycles", cyc, N + 1);
    check_output("no_overrun", overrun, 0);

    $display("[TB] bit-reversed fill, backpressure, overrun mid-drain");
    apply_stimulus(1);
    drain_check(1, N, 1000, 3, 1'b1, cyc);
    check_output("overrun_set", overrun, 1);
    check_output("overrun_count_3", overrun_count, CNT_EN ? ovr_cnt : 0);

    $display("[TB] random fill, overrun on final transfer");
    apply_stimulus(2);
    drain_check(0, N, N - 1, 1, 1'b0, cyc);
    check_output("final_ovr_cycles", cyc, N + 1);
    check_output("overrun_count_4", overrun_count, CNT_EN ? ovr_cnt : 0);

    $display("[TB] reset mid-drain");
    apply_stimulus(2);
    drain_check(0, 100, N, 0, 1'b0, cyc);
    rst = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    ovr_cnt = 0;
    check_output("abort_valid", m_valid, 0);
    check_output("abort_data", m_data, 0);
    check_output("abort_index", m_index, 0);
    check_output("abort_last", m_last, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_overrun", overrun, 0);
    check_output("abort_overrun_count", overrun_count, 0);
    rst = 1'b0;

    $display("[TB] fresh fill after reset, random ready");
    apply_stimulus(2);
    drain_check(2, N, N, 0, 1'b0, cyc);
    check_output("fresh_overrun", overrun, 0);
    check_output("fresh_overrun_count", overrun_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
